// File: rtl/elementwise_engine_v2_if.sv
// Operand A/B and result streams of the elementwise engine.
// Each beat carries TOUT signed lanes of DW bits.
interface elementwise_engine_v2_if #(
  parameter int TOUT = 32,
  parameter int DW   = 16
);
  logic                 a_valid;
  logic                 a_ready;
  logic [TOUT*DW-1:0]   a_data;
  logic                 b_valid;
  logic                 b_ready;
  logic [TOUT*DW-1:0]   b_data;
  logic                 o_valid;
  logic                 o_ready;
  logic [TOUT*DW-1:0]   o_data;
  logic                 o_last;

  modport master (
    output a_valid, a_data,
    output b_valid, b_data,
    output o_ready,
    input  a_ready, b_ready,
    input  o_valid, o_data, o_last
  );

  modport slave (
    input  a_valid, a_data,
    input  b_valid, b_data,
    input  o_ready,
    output a_ready, b_ready,
    output o_valid, o_data, o_last
  );
endinterface

// File: rtl/elementwise_engine_v2.sv
// Elementwise A op B engine: joins two lane streams, computes
// per lane in stage 1, saturates and registers in stage 2.
module elementwise_engine_v2 #(
  parameter int TOUT  = 32,
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           cfg_mode,
  input  logic [CNT_W-1:0]     cfg_h,
  input  logic [CNT_W-1:0]     cfg_w,
  input  logic [CNT_W-1:0]     cfg_ch_div_tout,
  input  logic [4:0]           cfg_shift,
  elementwise_engine_v2_if.slave s,
  output logic                 busy,
  output logic                 done,
  output logic                 err_mode
);

  localparam int NW = 3 * CNT_W;
  localparam int PW = 2 * DW;
  localparam int BW = TOUT * DW;

  localparam logic signed [PW-1:0] SMAX =
    {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN =
    {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [2:0]      mode_q;
  logic [4:0]      shift_q;
  logic [NW-1:0]   n_q;
  logic [NW-1:0]   in_cnt_q;

  logic            s1_v_q;
  logic            s1_last_q;
  logic [TOUT-1:0][PW-1:0] s1_res_q;
  logic [TOUT-1:0][PW-1:0] s1_res_d;

  logic            o_v_q;
  logic            o_last_q;
  logic [BW-1:0]   o_data_q;
  logic [BW-1:0]   sat_d;

  logic [NW-1:0]   n_cfg;
  logic            mode_bad;
  logic            run;
  logic            more;
  logic            s2_adv;
  logic            s1_adv;
  logic            join_go;
  logic            last_in;
  logic            out_fire;

  // Full-precision lane result; wide enough for every mode.
  function automatic logic signed [PW-1:0] lane_op(
    input logic [2:0]           m,
    input logic [4:0]           sh,
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b
  );
    logic signed [PW-1:0] ae;
    logic signed [PW-1:0] be;
    logic signed [PW-1:0] df;
    logic signed [PW-1:0] r;
    ae = a;
    be = b;
    df = ae - be;
    case (m)
      3'd0:    r = ae + be;
      3'd1:    r = df;
      3'd2:    r = (ae * be) >>> sh;
      3'd3:    r = (ae > be) ? ae : be;
      3'd4:    r = (ae < be) ? ae : be;
      3'd5:    r = (df < 0) ? -df : df;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Clamp a wide lane result into the DW-bit signed range.
  function automatic logic [DW-1:0] sat_lane(
    input logic signed [PW-1:0] r
  );
    logic [DW-1:0] y;
    unique case (1'b1)
      (r > SMAX): y = SMAX[DW-1:0];
      (r < SMIN): y = SMIN[DW-1:0];
      default:    y = r[DW-1:0];
    endcase
    return y;
  endfunction

  assign n_cfg = NW'(cfg_h) * NW'(cfg_w)
               * NW'(cfg_ch_div_tout);
  assign mode_bad = cfg_mode > 3'd5;

  assign run      = !rst && (state_q == S_RUN);
  assign more     = in_cnt_q < n_q;
  assign s2_adv   = !o_v_q || s.o_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign join_go  = run && more && s1_adv
                  && s.a_valid && s.b_valid;
  assign last_in  = in_cnt_q == (n_q - NW'(1));
  assign out_fire = o_v_q && s.o_ready;

  assign s.a_ready = run && more && s1_adv && s.b_valid;
  assign s.b_ready = run && more && s1_adv && s.a_valid;

  assign s.o_valid = o_v_q;
  assign s.o_data  = o_data_q;
  assign s.o_last  = o_last_q;

  assign busy     = busy_q;
  assign done     = done_q;
  assign err_mode = err_q;

  // Stage 1 lane arithmetic on the joined A/B beat.
  always_comb begin
    s1_res_d = '0;
    for (int i = 0; i < TOUT; i++) begin
      s1_res_d[i] = lane_op(mode_q, shift_q,
                            s.a_data[i*DW +: DW],
                            s.b_data[i*DW +: DW]);
    end
  end

  // Stage 2 saturation of the registered stage 1 lanes.
  always_comb begin
    sat_d = '0;
    for (int i = 0; i < TOUT; i++) begin
      sat_d[i*DW +: DW] = sat_lane(s1_res_q[i]);
    end
  end

  // Job control: config latch, beat count, status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mode_q   <= '0;
      shift_q  <= '0;
      n_q      <= '0;
      in_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q   <= cfg_mode;
            shift_q  <= cfg_shift;
            n_q      <= n_cfg;
            in_cnt_q <= '0;
            err_q    <= mode_bad;
            if (mode_bad || (n_cfg == '0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (join_go) begin
            in_cnt_q <= in_cnt_q + NW'(1);
            if (last_in) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (out_fire && o_last_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage elastic pipe; a stage moves when its
  // successor moves or it holds nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      s1_res_q  <= '0;
      o_v_q     <= 1'b0;
      o_last_q  <= 1'b0;
      o_data_q  <= '0;
    end else begin
      if (s1_adv) begin
        s1_v_q <= join_go;
        if (join_go) begin
          s1_res_q  <= s1_res_d;
          s1_last_q <= last_in;
        end
      end
      if (s2_adv) begin
        o_v_q    <= s1_v_q;
        o_last_q <= s1_v_q && s1_last_q;
        if (s1_v_q) begin
          o_data_q <= sat_d;
        end
      end
    end
  end

endmodule
